// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, FSM state type and palette for the bouncing box
//
// Holds the default active-area sizes, the box reset position, the frame FSM
// state enum and the 8-entry 12-bit palette used when the colour-cycle build
// option VGA_BOUNCE_COLOR_CYCLE_EN is defined.
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    localparam logic [9:0] PX_RESET = 10'd64;
    localparam logic [9:0] PY_RESET = 10'd48;

    localparam logic [11:0] BG_COLOR        = 12'h00F;
    localparam logic [11:0] BOX_COLOR_FIXED = 12'hFFF;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } frame_state_e;

    // Entry 0 is the rightmost element.
    localparam logic [7:0][11:0] PALETTE = {
        12'h8F8, 12'hF80, 12'hF0F, 12'h0FF,
        12'hFF0, 12'h0F0, 12'hF00, 12'hFFF
    };

    function automatic logic [11:0] palette_lookup(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// rtl/vga_bounce_axis.sv - one axis of box position, direction and edge bounce
//
// Parameters: ACT (active size on this axis), BOX (box side), STEP (pixels per
// update), RESET_POS (position after reset).
// Ports:
//   clk       pixel clock
//   rst       synchronous active-high reset (pos=RESET_POS, dir=1)
//   update_i  one-cycle pulse: apply one movement step
//   pos_o     current box position on this axis (never exceeds ACT-BOX)
//   dir_o     1 = moving towards larger coordinates
//   bounce_o  the next update hits an edge and flips direction
module vga_bounce_axis #(
    parameter int         ACT       = 640,
    parameter int         BOX       = 32,
    parameter int         STEP      = 2,
    parameter logic [9:0] RESET_POS = 10'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update_i,
    output logic [9:0] pos_o,
    output logic       dir_o,
    output logic       bounce_o
);

    localparam logic [10:0] LIMIT  = 11'(ACT - BOX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic        bounce;
    logic [10:0] sum, diff;

    // 11-bit arithmetic so pos+STEP near 1023 cannot wrap before the clamp test.
    assign sum  = {1'b0, pos_q} + STEP11;
    assign diff = {1'b0, pos_q} - STEP11;

    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        bounce = 1'b0;
        if (dir_q) begin
            if (sum > LIMIT) begin
                pos_d  = LIMIT[9:0];
                dir_d  = 1'b0;
                bounce = 1'b1;
            end else begin
                pos_d = sum[9:0];
            end
        end else begin
            if ({1'b0, pos_q} < STEP11) begin
                pos_d  = 10'd0;
                dir_d  = 1'b1;
                bounce = 1'b1;
            end else begin
                pos_d = diff[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= RESET_POS;
            dir_q <= 1'b1;
        end else if (update_i) begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // Only the low 10 bits are stored; the carry bits serve the compares above.
    logic unused_msb;
    assign unused_msb = sum[10] ^ diff[10];

    assign pos_o    = pos_q;
    assign dir_o    = dir_q;
    assign bounce_o = bounce;

endmodule

// File: rtl/vga_bounce.sv
// rtl/vga_bounce.sv - bouncing box overlay on a VGA timing stream
//
// Build option: VGA_BOUNCE_COLOR_CYCLE_EN selects the palette colour cycle
// (index steps once per bouncing update); undefined gives a fixed white box.
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   de_in/hs_in/vs_in  timing from the generator (active-high)
//   r_out/g_out/b_out  4-bit colour, registered, 1 cycle after de_in
//   hs_out/vs_out      hs_in/vs_in delayed one cycle
module vga_bounce
    import vga_pkg::*;
#(
    parameter int BOX   = 32,
    parameter int STEP  = 2,
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de_in,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic [3:0] r_out,
    output logic [3:0] g_out,
    output logic [3:0] b_out,
    output logic       hs_out,
    output logic       vs_out
);

    localparam logic [10:0] BOX11 = 11'(BOX);

    frame_state_e state_q;
    logic [9:0]   x_q, x_d, y_q, y_d;
    logic         de_q, hs_q, vs_q;
    logic [11:0]  rgb_q;
    logic         vs_rise, de_fall, update;
    logic [9:0]   px, py;
    logic         dx, dy, bounce_x, bounce_y;
    logic         in_box;
    logic [11:0]  box_color;

    // vs_q doubles as the delayed vs output and the edge-detect history.
    assign vs_rise = vs_in & ~vs_q;
    assign de_fall = de_q & ~de_in;
    assign update  = vs_rise && (state_q == RUN);

    vga_bounce_axis #(
        .ACT(H_ACT), .BOX(BOX), .STEP(STEP), .RESET_POS(PX_RESET)
    ) u_axis_x (
        .clk(clk), .rst(rst), .update_i(update),
        .pos_o(px), .dir_o(dx), .bounce_o(bounce_x)
    );

    vga_bounce_axis #(
        .ACT(V_ACT), .BOX(BOX), .STEP(STEP), .RESET_POS(PY_RESET)
    ) u_axis_y (
        .clk(clk), .rst(rst), .update_i(update),
        .pos_o(py), .dir_o(dy), .bounce_o(bounce_y)
    );

    logic unused_dir;
    assign unused_dir = dx ^ dy;

`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
    logic [2:0] idx_q;

    // A corner flips both axes in one update but advances the index once.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 3'd0;
        end else if (update && (bounce_x || bounce_y)) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    assign box_color = palette_lookup(idx_q);
`else
    logic unused_bounce;
    assign unused_bounce = bounce_x ^ bounce_y;
    assign box_color     = BOX_COLOR_FIXED;
`endif

    // x counts visible pixels already seen on this line, so it equals the
    // coordinate of the pixel currently presented on de_in.
    always_comb begin
        x_d = 10'd0;
        if (de_in) begin
            x_d = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
        end
        y_d = y_q;
        if (vs_rise) begin
            y_d = 10'd0;
        end else if (de_fall && (y_q != 10'h3FF)) begin
            y_d = y_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            de_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_in;
        end
    end

    assign in_box = ({1'b0, x_q} >= {1'b0, px}) && ({1'b0, x_q} < ({1'b0, px} + BOX11)) &&
                    ({1'b0, y_q} >= {1'b0, py}) && ({1'b0, y_q} < ({1'b0, py} + BOX11));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_SYNC;
            rgb_q   <= 12'h000;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            case (state_q)
                WAIT_SYNC: if (vs_rise) state_q <= RUN;
                RUN:       state_q <= RUN;
                default:   state_q <= WAIT_SYNC;
            endcase
            if ((state_q == RUN) && de_in) begin
                rgb_q <= in_box ? box_color : BG_COLOR;
            end else begin
                rgb_q <= 12'h000;
            end
        end
    end

    assign r_out  = rgb_q[11:8];
    assign g_out  = rgb_q[7:4];
    assign b_out  = rgb_q[3:0];
    assign hs_out = hs_q;
    assign vs_out = vs_q;

endmodule
